// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory writer. It takes a little-endian byte stream,
// packs every four bytes into a 32-bit word and writes the words to
// consecutive word-aligned instruction-memory addresses starting at 0. The core
// is held in reset until the requested number of words has been written.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the last word. It must equal the
//   modulo-256 sum of all data bytes of the session. A mismatch raises err and
//   returns to IDLE with the core still in reset. When undefined, err is 0 and
//   the last write goes straight to DONE.
//
// Ports
//   clk          in   system clock, rising edge
//   areset       in   synchronous active-high reset
//   start        in   one-cycle request to begin a session (IDLE/DONE only)
//   word_count   in   words to load, sampled on accepted start, saturated
//                     to 2^ADDR_W
//   byte_valid   in   byte source has a byte on byte_data
//   byte_data    in   stream byte
//   byte_ready   out  loader accepts a byte this cycle
//   imem_we      out  instruction-memory write strobe (single cycle)
//   imem_addr    out  word-aligned byte address {word_idx, 2'b00}
//   imem_wd      out  assembled instruction word
//   cpu_reset    out  registered core reset, low only in DONE
//   busy         out  session in progress (RECV/WRITE/CHECK)
//   done         out  load completed successfully
//   err          out  checksum mismatch on last session
//   o_dbg_state  out  current FSM state encoding
//
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready are
// both high. byte_ready depends only on the current state, never on
// byte_valid. byte_data is ignored on any other cycle, so gaps in byte_valid
// simply stall the loader.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Largest loadable count: the full memory, 2^ADDR_W words.
  localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [1:0]          r_byte_idx;
  logic [31:0]         r_word;
  logic                r_cpu_reset;

  logic                w_byte_ready;
  logic                w_xfer;
  logic                w_start_ok;
  logic [ADDR_W:0]     w_count_sat;
  logic                w_last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic                r_err;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    w_byte_ready = (r_state == S_RECV) || (r_state == S_CHECK);
    w_xfer       = byte_valid && w_byte_ready;
    // start only counts where no session is running.
    w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_count_sat  = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
    // Widened by one bit so a full 2^ADDR_W-word load terminates correctly.
    w_last_word  = (({1'b0, r_word_idx}) + CNT_ONE) == r_count;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          if (w_count_sat == '0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt = S_CHECK;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_state_nxt = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (w_xfer && (r_byte_idx == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_xfer) begin
          w_state_nxt = (byte_data == r_sum) ? S_DONE : S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      // Registered so the core sees a glitch-free release in DONE only.
      r_cpu_reset <= (w_state_nxt != S_DONE);

      if (w_start_ok) begin
        r_count    <= w_count_sat;
        r_word_idx <= '0;
        r_byte_idx <= '0;
      end

      if ((r_state == S_RECV) && w_xfer) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= byte_data;
        r_byte_idx <= r_byte_idx + 2'd1;
      end

      if (r_state == S_WRITE) begin
        r_word_idx <= r_word_idx + IDX_ONE;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (areset) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_sum <= '0;
        r_err <= 1'b0;
      end else if ((r_state == S_RECV) && w_xfer) begin
        r_sum <= r_sum + byte_data;
      end else if ((r_state == S_CHECK) && w_xfer && (byte_data != r_sum)) begin
        r_err <= 1'b1;
      end
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign byte_ready  = w_byte_ready;
  assign imem_we     = (r_state == S_WRITE);
  assign imem_addr   = 32'({r_word_idx, 2'b00});
  assign imem_wd     = r_word;
  assign cpu_reset   = r_cpu_reset;
  assign busy        = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_CHECK);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a little-endian byte stream over a valid/ready handshake and assembles the bytes into 32-bit words. Each word is written into consecutive word-aligned instruction-memory locations. The core is held in reset throughout, and released only when the programmed number of words has been written (and, optionally, the checksum has passed). It sits between a byte source (UART receiver, debug port) and the instruction-memory write port, alongside the core top.

## Interface

Parameters
- ADDR_W, 8, word-address bits of instruction memory (capacity 2^ADDR_W words)

Ports
- clk  in  1  system clock, all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to begin a load session
- word_count  in  ADDR_W+1  number of words to load, sampled on accepted start
- byte_valid  in  1  byte source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  32  byte address of write, word-aligned: {word_idx, 2'b00}, zero-extended
- imem_wd  out  32  assembled instruction word
- cpu_reset  out  1  hold core in reset (active-high), registered
- busy  out  1  session in progress
- done  out  1  load completed successfully
- err  out  1  checksum mismatch on last session

## Operation

- States: IDLE, RECV, WRITE, CHECK, DONE.
- IDLE: byte_ready=0, cpu_reset=1. On start=1:
  - capture word_count, saturated to 2^ADDR_W;
  - clear word_idx, byte_idx, sum and err;
  - go to RECV, or go to CHECK/DONE directly if the count is 0.
- RECV: byte_ready=1. A byte is transferred only when byte_valid && byte_ready.
  - Byte k (0..3) lands in word bits [8k+7:8k].
  - The 4th transfer moves to WRITE.
- WRITE: one cycle with imem_we=1 and byte_ready=0; imem_addr and imem_wd are stable.
  - Then word_idx increments.
  - If word_idx+1 == count, go to CHECK (macro on) or DONE; otherwise go to RECV.
- CHECK (macro only): byte_ready=1. One byte is accepted and compared to the checksum.
  - Match: go to DONE.
  - Mismatch: err=1, go to IDLE with cpu_reset=1.
- DONE: done=1, cpu_reset=0, busy=0. A start here re-enters a session: cpu_reset=1 on the next cycle, and a new load begins.
- start is ignored while busy (RECV/WRITE/CHECK).
- busy=1 in RECV, WRITE and CHECK.
- byte_data is ignored when the transfer condition is false. Gaps in byte_valid stall the loader without side effects.

## Timing

- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wd=0, cpu_reset=1, busy=0, done=0, err=0. State is IDLE.
- Reset mid-session: on the next edge the loader returns to IDLE. The partial word is discarded, no write is issued, and cpu_reset stays 1. Words already written remain in memory. areset has priority over start.
- start accepted in IDLE: byte_ready=1 from the next cycle.
- Minimum 5 cycles per word: 4 byte transfers plus 1 WRITE cycle.
- Last WRITE (or accepted checksum byte) to done=1/cpu_reset=0: 1 cycle.
- imem_we is never high for more than one consecutive cycle.
- imem_addr wrap cannot occur, because the count saturates at 2^ADDR_W. The final address is (count-1)*4.

## Configuration

- LOADER_CHECKSUM_EN defined:
  - One extra byte follows the last word.
  - It must equal the 8-bit modulo-256 sum of all data bytes of the session.
  - A count of 0 still expects the checksum byte, which must be 0x00.
- LOADER_CHECKSUM_EN undefined:
  - The CHECK state is absent; the last WRITE goes directly to DONE.
  - err is tied to 0.

## Test plan

- Reset: assert areset 2 cycles -> cpu_reset=1, imem_we=0, byte_ready=0, done=0, err=0.
- Two words, count=2, bytes 13 00 50 00 B3 00 21 00 streamed back-to-back (plus checksum 0x37 if enabled):
  - writes 0x00500013 at address 0x0, then 0x002100B3 at address 0x4;
  - done=1 and cpu_reset=0 one cycle after the final acceptance.
- Same stream with byte_valid toggled randomly (random 0–3 cycle gaps between bytes) -> identical writes, exactly two imem_we pulses, no duplicated or dropped bytes.
- Reset after 2 bytes of word 0, then restart with count=1, bytes 78 56 34 12 -> single write 0x12345678 at 0x0, no write before the reset.
- Checksum enabled, count=1, bytes 01 02 03 04 with checksum 0x0B -> one write, err=1, done=0, cpu_reset stays 1. With checksum 0x0A -> done=1.
- start pulsed during RECV -> ignored, count unchanged. start in DONE -> cpu_reset=1 next cycle, new session writes from address 0x0.
